// File: rtl/pwm_ramp_ctrl_if.sv
// Configuration handshake between the CPU/config register block and pwm_ramp_ctrl.
interface pwm_ramp_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_duty;
  logic [WIDTH-1:0] cfg_step;

  modport master (
    output cfg_valid, cfg_period, cfg_duty, cfg_step,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_duty, cfg_step,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty/period sequencer: applies shadow config at period boundaries and ramps duty to target.
// Optional macro PWM_DUTY_CLAMP_EN clamps the applied target duty to the applied period.
module pwm_ramp_ctrl #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEFAULT_PERIOD = 1000,
  parameter int unsigned RAMP_DIV       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  pwm_ramp_ctrl_if.slave   cfg_if,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] duty_cycle_o,
  output logic             period_start_o,
  output logic             busy_o,
  output logic             ramp_done_o
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_RUN
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] step_q;
  logic [DIV_W-1:0] div_q;
  logic [WIDTH-1:0] pend_period_q;
  logic [WIDTH-1:0] pend_duty_q;
  logic [WIDTH-1:0] pend_step_q;
  logic             pend_valid_q;
  logic             cfg_ready_q;
  logic             period_start_q;
  logic             busy_q;
  logic             ramp_done_q;

  logic             boundary;
  logic             accept;
  logic             apply;
  logic [WIDTH-1:0] goal;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_dif;
  logic [WIDTH-1:0] duty_d;

  // period_q - 1 wraps to all-ones for period 0, matching the PWM's 2^WIDTH period.
  assign boundary = (cnt_q == (period_q - WIDTH'(1)));
  assign accept   = cfg_if.cfg_valid && cfg_ready_q;
  // pend_valid_q rises the cycle after acceptance, so a boundary coinciding with it is skipped.
  assign apply    = boundary && pend_valid_q;
  assign goal     = enable_i ? target_q : '0;

`ifdef PWM_DUTY_CLAMP_EN
  assign pend_target = (pend_duty_q > pend_period_q) ? pend_period_q : pend_duty_q;
`else
  assign pend_target = pend_duty_q;
`endif

  always_comb begin
    up_sum = {1'b0, duty_q} + {1'b0, step_q};
    dn_dif = {1'b0, duty_q} - {1'b0, step_q};
    duty_d = goal;
    if (step_q != '0) begin
      if (duty_q < goal) begin
        if (up_sum < {1'b0, goal}) duty_d = up_sum[WIDTH-1:0];
      end else if (duty_q > goal) begin
        if (!dn_dif[WIDTH] && (dn_dif[WIDTH-1:0] > goal)) duty_d = dn_dif[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      period_q       <= WIDTH'(DEFAULT_PERIOD);
      duty_q         <= '0;
      target_q       <= '0;
      step_q         <= '0;
      div_q          <= '0;
      pend_period_q  <= '0;
      pend_duty_q    <= '0;
      pend_step_q    <= '0;
      pend_valid_q   <= 1'b0;
      cfg_ready_q    <= 1'b1;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
      ramp_done_q    <= 1'b0;
    end else begin
      period_start_q <= boundary;
      ramp_done_q    <= 1'b0;
      cnt_q          <= boundary ? '0 : cnt_q + WIDTH'(1);

      if (accept) begin
        pend_period_q <= cfg_if.cfg_period;
        pend_duty_q   <= cfg_if.cfg_duty;
        pend_step_q   <= cfg_if.cfg_step;
        pend_valid_q  <= 1'b1;
        cfg_ready_q   <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (goal != '0) begin
            state_q <= S_RAMP;
            busy_q  <= 1'b1;
            div_q   <= '0;
          end
        end
        S_RUN: begin
          if (goal != duty_q) begin
            state_q <= S_RAMP;
            busy_q  <= 1'b1;
            div_q   <= '0;
          end
        end
        S_RAMP: begin
          if (boundary) begin
            if (div_q == DIV_LAST) begin
              div_q  <= '0;
              duty_q <= duty_d;
              if (duty_d == goal) begin
                ramp_done_q <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= (goal != '0) ? S_RUN : S_IDLE;
              end
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Applying a config restarts the divider even if the ramp branch above advanced it.
      if (apply) begin
        period_q     <= pend_period_q;
        target_q     <= pend_target;
        step_q       <= pend_step_q;
        div_q        <= '0;
        pend_valid_q <= 1'b0;
        cfg_ready_q  <= 1'b1;
      end
    end
  end

  assign cfg_if.cfg_ready = cfg_ready_q;
  assign period_o         = period_q;
  assign duty_cycle_o     = duty_q;
  assign period_start_o   = period_start_q;
  assign busy_o           = busy_q;
  assign ramp_done_o      = ramp_done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl (WIDTH=16, DEFAULT_PERIOD=1000, RAMP_DIV=1).
module tb_pwm_ramp_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] duty_cycle;
  logic             period_start;
  logic             busy;
  logic             ramp_done;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n;
  int unsigned low_cnt;
  logic [31:0] exp_clamp;

  pwm_ramp_ctrl_if #(.WIDTH(WIDTH)) cfg_if ();

  pwm_ramp_ctrl #(
    .WIDTH         (WIDTH),
    .DEFAULT_PERIOD(1000),
    .RAMP_DIV      (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .cfg_if        (cfg_if.slave),
    .period_o      (period),
    .duty_cycle_o  (duty_cycle),
    .period_start_o(period_start),
    .busy_o        (busy),
    .ramp_done_o   (ramp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Counts clocks until period_start is seen (sampled on negedge), bounded by limit.
  task automatic wait_ps(input int unsigned limit, output int unsigned cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end while (!period_start && cycles < limit);
    if (!period_start) check_eq("ps_timeout", {31'd0, period_start}, 32'd1);
  endtask

  task automatic send_cfg(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] s);
    cfg_if.cfg_period = p;
    cfg_if.cfg_duty   = d;
    cfg_if.cfg_step   = s;
    cfg_if.cfg_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty   = '0;
    cfg_if.cfg_step   = '0;
`ifdef PWM_DUTY_CLAMP_EN
    exp_clamp = 32'd4;
`else
    exp_clamp = 32'd9;
`endif

    // Reset values, then idle period_start spacing
    repeat (3) @(negedge clk);
    check_eq("rst_period", period, 1000);
    check_eq("rst_duty", duty_cycle, 0);
    check_eq("rst_ready", cfg_if.cfg_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ps", period_start, 0);
    check_eq("rst_done", ramp_done, 0);
    rst_n = 1'b1;
    wait_ps(1100, n);
    check_eq("ps_first", n, 1000);
    wait_ps(1100, n);
    check_eq("ps_gap_1000", n, 1000);
    check_eq("idle_duty", duty_cycle, 0);

    // Mid-period config 10/6/2, ramp 0->2->4->6
    enable = 1'b1;
    send_cfg(10, 6, 2);
    check_eq("ready_low_after_acc", cfg_if.cfg_ready, 0);
    check_eq("period_held", period, 1000);
    wait_ps(1100, n);
    check_eq("apply_period", period, 10);
    check_eq("apply_duty", duty_cycle, 0);
    check_eq("apply_ready", cfg_if.cfg_ready, 1);
    wait_ps(20, n);
    check_eq("ps_gap_10", n, 10);
    check_eq("up_duty_2", duty_cycle, 2);
    check_eq("up_busy_2", busy, 1);
    wait_ps(20, n);
    check_eq("up_duty_4", duty_cycle, 4);
    check_eq("up_busy_4", busy, 1);
    wait_ps(20, n);
    check_eq("up_duty_6", duty_cycle, 6);
    check_eq("up_done", ramp_done, 1);
    check_eq("up_busy_end", busy, 0);
    @(negedge clk);
    check_eq("up_done_pulse", ramp_done, 0);

    // Drop enable: 6->4->2->0, then raise: 0->2->4->6
    enable = 1'b0;
    wait_ps(20, n);
    check_eq("dn_duty_4", duty_cycle, 4);
    check_eq("dn_busy", busy, 1);
    wait_ps(20, n);
    check_eq("dn_duty_2", duty_cycle, 2);
    wait_ps(20, n);
    check_eq("dn_duty_0", duty_cycle, 0);
    check_eq("dn_done", ramp_done, 1);
    check_eq("dn_busy_end", busy, 0);
    enable = 1'b1;
    wait_ps(20, n);
    check_eq("re_duty_2", duty_cycle, 2);
    wait_ps(20, n);
    check_eq("re_duty_4", duty_cycle, 4);
    wait_ps(20, n);
    check_eq("re_duty_6", duty_cycle, 6);
    check_eq("re_done", ramp_done, 1);

    enable = 1'b0;
    for (int i = 0; i < 3; i++) wait_ps(20, n);
    check_eq("off_duty", duty_cycle, 0);
    check_eq("off_busy", busy, 0);

    // Config offered in the boundary cycle; a second offer while not ready is ignored
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_eq("pre_bnd_ps", period_start, 0);
    cfg_if.cfg_period = 8;
    cfg_if.cfg_duty   = 5;
    cfg_if.cfg_step   = 3;
    cfg_if.cfg_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bnd_acc_ps", period_start, 1);
    check_eq("bnd_acc_ready", cfg_if.cfg_ready, 0);
    check_eq("bnd_period_old", period, 10);
    cfg_if.cfg_period = 20;
    cfg_if.cfg_duty   = 1;
    cfg_if.cfg_step   = 0;
    low_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (cfg_if.cfg_ready) break;
      low_cnt++;
    end
    cfg_if.cfg_valid = 1'b0;
    check_eq("ready_low_cycles", low_cnt, 10);
    check_eq("bnd_apply_ps", period_start, 1);
    check_eq("bnd_apply_period", period, 8);

    // Saturating ramp 0->3->5
    enable = 1'b1;
    wait_ps(20, n);
    check_eq("ps_gap_8", n, 8);
    check_eq("sat_duty_3", duty_cycle, 3);
    check_eq("sat_busy", busy, 1);
    wait_ps(20, n);
    check_eq("sat_duty_5", duty_cycle, 5);
    check_eq("sat_done", ramp_done, 1);
    wait_ps(20, n);
    check_eq("sat_hold_5", duty_cycle, 5);
    check_eq("second_cfg_ignored", period, 8);

    // step=0 jump; target clamp depends on PWM_DUTY_CLAMP_EN
    send_cfg(4, 9, 0);
    wait_ps(20, n);
    check_eq("jmp_period", period, 4);
    check_eq("jmp_duty_before", duty_cycle, 5);
    wait_ps(20, n);
    check_eq("ps_gap_4", n, 4);
    check_eq("jmp_duty", duty_cycle, exp_clamp);
    check_eq("jmp_done", ramp_done, 1);

    // Asynchronous reset in the middle of a ramp
    send_cfg(5, 30, 1);
    wait_ps(20, n);
    check_eq("ar_period", period, 5);
    @(negedge clk);
    check_eq("ar_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_period_rst", period, 1000);
    check_eq("ar_duty_rst", duty_cycle, 0);
    check_eq("ar_busy_rst", busy, 0);
    check_eq("ar_ready_rst", cfg_if.cfg_ready, 1);
    check_eq("ar_ps_rst", period_start, 0);
    check_eq("ar_done_rst", ramp_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
